uart_mem: RTL
=============

Name: uart_mem

Overview:
- UART responder (memory-side end) for the mem_uart bridge protocol.
- Receives command frames on i_uart_rx and decodes them into write or read transactions.
- Performs each transaction on a valid/accept memory port.
- Replies on o_uart_tx with an ack byte (write) or the read data (read).
- Sits in the target FPGA between the UART pins and a local RAM/register file.

Parameters:
- DATA_WIDTH, 16, memory data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 64, memory address width in bits; must be a multiple of 8.
- SAMPLE, 1250, clocks per UART bit (CLK_HZ / BAUDRATE).
- TIMEOUT, 65535, maximum idle clocks between bytes inside a frame before the frame is aborted.

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  reset; asynchronous, active-low.
- i_uart_rx  in  1  serial in, idle high.
- o_uart_tx  out  1  serial out, idle high.
- o_addr  out  ADDR_WIDTH  transaction address.
- o_data  out  DATA_WIDTH  write data.
- i_data  in  DATA_WIDTH  read data; sampled on the read-accept cycle.
- o_write_valid  out  1  write request.
- i_write_accept  in  1  write handshake.
- o_read_valid  out  1  read request.
- i_read_accept  in  1  read handshake.

Behaviour:
- Reset values: o_uart_tx=1; o_write_valid=0; o_read_valid=0; o_addr=0; o_data=0; FSM=IDLE; bit, byte and timeout counters=0.
- Reset mid-operation aborts everything immediately; tx returns high in the same cycle.
- Line format is 8N1, LSB first, SAMPLE clocks per bit.
- RX path:
  - i_uart_rx is double-flopped.
  - A falling edge starts a byte; the start bit is re-sampled at SAMPLE/2 and, if high, treated as a glitch and ignored.
  - Data bits are sampled every SAMPLE thereafter.
  - Stop bit must be 1; if 0, it is a framing error: the byte is discarded and the FSM returns to IDLE.
- Frame formats (multi-byte fields MSB byte first; NA = ADDR_WIDTH/8, ND = DATA_WIDTH/8):
  - Write: 0x57, NA address bytes, ND data bytes.
  - Read: 0x52, NA address bytes.
- FSM states:
  - IDLE: on byte 0x57 go to ADDR (write flag); on 0x52 go to ADDR (read flag); on any other byte go to RESP with response 0x3F.
  - ADDR: shift bytes into o_addr; after NA bytes go to WDATA (write) or MEM_RD (read).
  - WDATA: shift bytes into o_data; after ND bytes go to MEM_WR.
  - MEM_WR: o_write_valid=1, with o_addr and o_data held stable. On the first edge where i_write_accept=1, drop valid and go to RESP with response 0x4B.
  - MEM_RD: o_read_valid=1. On the accept edge, capture i_data into the tx shift register, drop valid, and go to RESP with ND bytes, MSB first.
  - RESP: transmit the queued bytes back-to-back (start, 8 data, stop; 10*SAMPLE clocks per byte), then go to IDLE.
- Accept while valid=0 is ignored. Valid never deasserts without an accept; there is no memory-side timeout.
- Latency: the request is raised on the clock after the stop-bit sample of the last frame byte. The TX start bit begins on the clock after accept.
- Inter-byte timeout: in ADDR or WDATA, if TIMEOUT clocks elapse with no start bit, return to IDLE silently and discard the partial frame. The counter resets on each received byte.
- RX bytes arriving while in MEM_WR, MEM_RD or RESP are dropped (half-duplex protocol).
- Address and data widths are exact; no wrap or truncation.

Decomposition:
- Package uart_mem_pkg:
  - command constants CMD_WR=8'h57, CMD_RD=8'h52;
  - response constants RSP_ACK=8'h4B, RSP_ERR=8'h3F;
  - state enum.
- One sub-module, uart_byte: SAMPLE-parameterised 8N1 byte engine with rx and tx.
  - rx side: rx_valid, rx_byte, rx_ferr.
  - tx side: tx_valid, tx_byte, tx_ready.
  - uart_mem instantiates it once.

Test Plan:
- Write: send 57, 01 23 45 67 89 AB CD EF, AB CD; hold i_write_accept=0 for 5 clocks then 1 -> o_write_valid high throughout with o_addr=0123456789ABCDEF and o_data=ABCD; valid drops after accept; tx returns 4B.
- Read: send 52, 00..00 10; on o_read_valid assert i_read_accept with i_data=BEEF -> tx returns BE then EF; valid is high for exactly the accept cycle plus the wait cycles.
- Bad command: send 7A -> tx returns 3F; no memory valid asserted.
- Timeout: send 57 plus 3 address bytes, then idle > TIMEOUT clocks -> no tx; a following valid read frame completes normally.
- Framing error: send a byte with stop bit 0 during ADDR -> FSM returns to IDLE; no valid and no tx.
- Reset mid-RESP: assert i_nrst low during the 2nd read-data byte -> o_uart_tx=1 immediately and all outputs at reset values.

Source files
------------

// File: rtl/uart_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_mem_pkg : command/response codes and FSM state type for uart_mem
// Revision: 1.0
// ---------------------------------------------------------------------------
package uart_mem_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WDATA  = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_MEM_RD = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mem_byte.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_byte : 8N1 byte engine, SAMPLE clocks per bit, independent rx and tx
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_byte #(
    parameter int SAMPLE = 1250
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_ferr,
    output logic       o_rx_busy,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready
);

    localparam int              c_CW   = $clog2(SAMPLE + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(SAMPLE - 1);
    localparam logic [c_CW-1:0] c_HALF = c_CW'(SAMPLE / 2 - 1);

    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    logic            r_rx_busy, r_rx_valid, r_rx_ferr;
    logic [c_CW-1:0] r_rx_cnt;
    logic [3:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;

    logic            r_tx, r_tx_busy;
    logic [c_CW-1:0] r_tx_cnt;
    logic [3:0]      r_tx_bit;
    logic [8:0]      r_tx_shift;
    logic            w_tx_last;

    assign o_rx_valid = r_rx_valid;
    assign o_rx_ferr  = r_rx_ferr;
    assign o_rx_byte  = r_rx_shift;
    assign o_rx_busy  = r_rx_busy;
    assign o_tx       = r_tx;

    // Ready one cycle early on the stop bit's final clock so queued bytes go out back-to-back.
    assign w_tx_last  = r_tx_busy && (r_tx_bit == 4'd9) && (r_tx_cnt == c_FULL);
    assign o_tx_ready = !r_tx_busy || w_tx_last;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_meta  <= i_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_sync) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= '0;
                    r_rx_bit  <= '0;
                end
            end else if (r_rx_bit == 4'd0) begin
                // Mid-start re-check: a high line here was only a glitch.
                if (r_rx_cnt == c_HALF) begin
                    r_rx_cnt <= '0;
                    if (r_rx_sync) r_rx_busy <= 1'b0;
                    else           r_rx_bit  <= 4'd1;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
            end else if (r_rx_cnt == c_FULL) begin
                r_rx_cnt <= '0;
                if (r_rx_bit == 4'd9) begin
                    r_rx_busy  <= 1'b0;
                    r_rx_valid <= r_rx_sync;
                    r_rx_ferr  <= !r_rx_sync;
                end else begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 1'b1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '1;
        end else if (i_tx_valid && o_tx_ready) begin
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= {1'b1, i_tx_byte};
        end else if (r_tx_busy) begin
            if (r_tx_cnt == c_FULL) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    r_tx_bit   <= r_tx_bit + 1'b1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_mem : UART command responder driving a valid/accept memory port
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_mem
    import uart_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int SAMPLE     = 1250,
    parameter int TIMEOUT    = 65535
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_uart_rx,
    output logic                  o_uart_tx,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_write_valid,
    input  logic                  i_write_accept,
    output logic                  o_read_valid,
    input  logic                  i_read_accept
);

    localparam logic [7:0]      c_NA_LAST = 8'(ADDR_WIDTH / 8 - 1);
    localparam logic [7:0]      c_ND_LAST = 8'(DATA_WIDTH / 8 - 1);
    localparam logic [7:0]      c_ND      = 8'(DATA_WIDTH / 8);
    localparam int              c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TLAST   = c_TW'(TIMEOUT - 1);

    state_t                r_state;
    logic                  r_is_rd;
    logic [7:0]            r_byte_cnt;
    logic [7:0]            r_tx_left;
    logic [c_TW-1:0]       r_tmo_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_tx_buf;
    logic                  r_wv, r_rv;

    logic       w_rx_valid, w_rx_ferr, w_rx_busy, w_tx_ready, w_tx_valid, w_tmo_hit;
    logic [7:0] w_rx_byte, w_tx_byte;

    assign o_addr        = r_addr;
    assign o_data        = r_data;
    assign o_write_valid = r_wv;
    assign o_read_valid  = r_rv;
    assign w_tx_valid    = (r_state == ST_RESP) && (r_tx_left != 8'd0);
    assign w_tx_byte     = r_tx_buf[DATA_WIDTH-1 -: 8];
    assign w_tmo_hit     = (r_tmo_cnt == c_TLAST);

    uart_byte #(.SAMPLE(SAMPLE)) u_byte (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_rx       (i_uart_rx),
        .o_tx       (o_uart_tx),
        .o_rx_valid (w_rx_valid),
        .o_rx_byte  (w_rx_byte),
        .o_rx_ferr  (w_rx_ferr),
        .o_rx_busy  (w_rx_busy),
        .i_tx_valid (w_tx_valid),
        .i_tx_byte  (w_tx_byte),
        .o_tx_ready (w_tx_ready)
    );

    // Counts only idle line time between frame bytes; a byte in flight holds it at zero.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)
            r_tmo_cnt <= '0;
        else if ((r_state == ST_ADDR || r_state == ST_WDATA) && !w_rx_busy && !w_rx_valid && !w_tmo_hit)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        else
            r_tmo_cnt <= '0;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= ST_IDLE;
            r_is_rd    <= 1'b0;
            r_byte_cnt <= '0;
            r_tx_left  <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_tx_buf   <= '0;
            r_wv       <= 1'b0;
            r_rv       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_byte_cnt <= '0;
                    if (w_rx_valid) begin
                        if (w_rx_byte == CMD_WR) begin
                            r_is_rd <= 1'b0;
                            r_state <= ST_ADDR;
                        end else if (w_rx_byte == CMD_RD) begin
                            r_is_rd <= 1'b1;
                            r_state <= ST_ADDR;
                        end else begin
                            r_tx_buf  <= DATA_WIDTH'(RSP_ERR) << (DATA_WIDTH - 8);
                            r_tx_left <= 8'd1;
                            r_state   <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_rx_ferr || w_tmo_hit) begin
                        r_state <= ST_IDLE;
                    end else if (w_rx_valid) begin
                        r_addr <= (r_addr << 8) | ADDR_WIDTH'(w_rx_byte);
                        if (r_byte_cnt == c_NA_LAST) begin
                            r_byte_cnt <= '0;
                            if (r_is_rd) begin
                                r_rv    <= 1'b1;
                                r_state <= ST_MEM_RD;
                            end else begin
                                r_state <= ST_WDATA;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_rx_ferr || w_tmo_hit) begin
                        r_state <= ST_IDLE;
                    end else if (w_rx_valid) begin
                        r_data <= (r_data << 8) | DATA_WIDTH'(w_rx_byte);
                        if (r_byte_cnt == c_ND_LAST) begin
                            r_byte_cnt <= '0;
                            r_wv       <= 1'b1;
                            r_state    <= ST_MEM_WR;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                ST_MEM_WR: begin
                    if (i_write_accept) begin
                        r_wv      <= 1'b0;
                        r_tx_buf  <= DATA_WIDTH'(RSP_ACK) << (DATA_WIDTH - 8);
                        r_tx_left <= 8'd1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_MEM_RD: begin
                    if (i_read_accept) begin
                        r_rv      <= 1'b0;
                        r_tx_buf  <= i_data;
                        r_tx_left <= c_ND;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_tx_valid && w_tx_ready) begin
                        r_tx_buf  <= r_tx_buf << 8;
                        r_tx_left <= r_tx_left - 1'b1;
                    end else if (r_tx_left == 8'd0 && w_tx_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
